// File: rtl/pu_msp430_pwm16_pkg.sv
// ---------------------------------------------------------------
// pu_msp430_pwm16_pkg : shared types and widths for the PWM block
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

package pu_msp430_pwm16_pkg;

    localparam int CNT_WD = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_state_t;

endpackage

`default_nettype wire

// File: rtl/pu_msp430_pwm16_if.sv
// ---------------------------------------------------------------
// pu_msp430_pwm16_if : control/status bundle of the PWM generator
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

interface pu_msp430_pwm16_if #(
    parameter int PRESC_WD = 4
);
    import pu_msp430_pwm16_pkg::*;

    logic                pwm_en;
    logic [PRESC_WD-1:0] pwm_presc;
    logic [CNT_WD-1:0]   period_cfg;
    logic [CNT_WD-1:0]   duty_cfg;
    logic                pwm_out;
    logic [CNT_WD-1:0]   pwm_cnt;
    logic                period_irq;
    logic                busy;

    modport master (
        output pwm_en, pwm_presc, period_cfg, duty_cfg,
        input  pwm_out, pwm_cnt, period_irq, busy
    );

    modport slave (
        input  pwm_en, pwm_presc, period_cfg, duty_cfg,
        output pwm_out, pwm_cnt, period_irq, busy
    );

endinterface

`default_nettype wire

// File: rtl/pu_msp430_pwm16_presc.sv
// ---------------------------------------------------------------
// pu_msp430_pwm16_presc : tick prescaler, divides mclk by presc+1
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module pu_msp430_pwm16_presc #(
    parameter int PRESC_WD = 4
) (
    input  wire logic                mclk,
    input  wire logic                puc_rst,
    input  wire logic                run,
    input  wire logic [PRESC_WD-1:0] pwm_presc,
    output logic                     tick
);

    logic [PRESC_WD-1:0] presc_cnt;

    // >= lets a live decrease of pwm_presc below presc_cnt tick at once
    assign tick = run && (presc_cnt >= pwm_presc);

    always_ff @(posedge mclk) begin
        if (puc_rst || !run) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_WD'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pu_msp430_pwm16.sv
// ---------------------------------------------------------------
// pu_msp430_pwm16 : double-buffered 16-bit PWM / period generator
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module pu_msp430_pwm16 #(
    parameter int PRESC_WD = 4
) (
    input  wire logic         mclk,
    input  wire logic         puc_rst,
    pu_msp430_pwm16_if.slave  bus
);
    import pu_msp430_pwm16_pkg::*;

    pwm_state_t        state, state_nxt;
    logic [CNT_WD-1:0] cnt, cnt_nxt;
    logic [CNT_WD-1:0] period_sh, period_sh_nxt;
    logic [CNT_WD-1:0] duty_sh, duty_sh_nxt;
    logic              out_q, out_nxt;
    logic              irq_q, irq_nxt;
    logic              run;
    logic              tick;
    logic              wrap;

    assign run  = (state != IDLE);
    assign wrap = tick && (cnt == period_sh);

    pu_msp430_pwm16_presc #(
        .PRESC_WD (PRESC_WD)
    ) u_presc (
        .mclk      (mclk),
        .puc_rst   (puc_rst),
        .run       (run),
        .pwm_presc (bus.pwm_presc),
        .tick      (tick)
    );

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        period_sh_nxt = period_sh;
        duty_sh_nxt   = duty_sh;
        irq_nxt       = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.pwm_en) begin
                    period_sh_nxt = bus.period_cfg;
                    duty_sh_nxt   = bus.duty_cfg;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_nxt       = '0;
                    irq_nxt       = 1'b1;
                    period_sh_nxt = bus.period_cfg;
                    duty_sh_nxt   = bus.duty_cfg;
                    if (!bus.pwm_en) state_nxt = IDLE;
                end else begin
                    if (tick) cnt_nxt = cnt + CNT_WD'(1);
                    if (!bus.pwm_en) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // A wrap always ends the drain, even if pwm_en returns that cycle
                if (wrap) begin
                    cnt_nxt   = '0;
                    irq_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    if (tick) cnt_nxt = cnt + CNT_WD'(1);
                    if (bus.pwm_en) state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        out_nxt = (state_nxt != IDLE) && (cnt_nxt < duty_sh_nxt);
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            period_sh <= '0;
            duty_sh   <= '0;
            out_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            period_sh <= period_sh_nxt;
            duty_sh   <= duty_sh_nxt;
            out_q     <= out_nxt;
            irq_q     <= irq_nxt;
        end
    end

    assign bus.pwm_out    = out_q;
    assign bus.pwm_cnt    = cnt;
    assign bus.period_irq = irq_q;
    assign bus.busy       = run;

endmodule

`default_nettype wire

// File: tb/tb_pu_msp430_pwm16.sv
// ---------------------------------------------------------------
// tb_pu_msp430_pwm16 : directed and random checks of the PWM block
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_pu_msp430_pwm16;

    logic mclk = 1'b0;
    logic puc_rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    pu_msp430_pwm16_if #(.PRESC_WD(4)) bus();

    pu_msp430_pwm16 #(.PRESC_WD(4)) dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .bus     (bus.slave)
    );

    always #5 mclk = ~mclk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: position within the current period, divider phase, and
    // whether the generator is active and/or winding down.
    bit          m_active = 0, m_stopping = 0, m_irq = 0, m_out = 0;
    int unsigned m_pos = 0, m_div = 0, m_per = 0, m_duty = 0;

    task automatic model_step();
        bit tick, wrapped;
        if (puc_rst) begin
            m_active = 0; m_stopping = 0; m_irq = 0;
            m_pos = 0; m_div = 0; m_per = 0; m_duty = 0;
        end else if (!m_active) begin
            m_irq = 0;
            if (bus.pwm_en) begin
                m_active = 1; m_stopping = 0; m_pos = 0; m_div = 0;
                m_per = bus.period_cfg; m_duty = bus.duty_cfg;
            end
        end else begin
            m_irq   = 0;
            tick    = (m_div >= int'(bus.pwm_presc));
            m_div   = tick ? 0 : m_div + 1;
            wrapped = 0;
            if (tick) begin
                if (m_pos == m_per) begin
                    m_pos = 0; m_irq = 1; wrapped = 1;
                    if (m_stopping || !bus.pwm_en) m_active = 0;
                    if (!m_stopping) begin
                        m_per = bus.period_cfg; m_duty = bus.duty_cfg;
                    end
                end else begin
                    m_pos++;
                end
            end
            if (!wrapped) m_stopping = !bus.pwm_en;
            if (!m_active) begin m_pos = 0; m_div = 0; m_stopping = 0; end
        end
        m_out = m_active && (m_pos < m_duty);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge mclk);
        model_step();
        #1;
        chk("out",  {31'd0, bus.pwm_out},    {31'd0, m_out});
        chk("cnt",  {16'd0, bus.pwm_cnt},    m_pos);
        chk("irq",  {31'd0, bus.period_irq}, {31'd0, m_irq});
        chk("busy", {31'd0, bus.busy},       {31'd0, m_active});
    endtask

    task automatic wait_cnt(input int unsigned v, input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            if (bus.pwm_cnt == v[15:0]) found = 1;
            else cyc();
        end
        chk("wait_cnt", {31'd0, found}, 32'd1);
    endtask

    task automatic start(input int unsigned p, input int unsigned d, input int unsigned pr);
        bus.period_cfg = p[15:0]; bus.duty_cfg = d[15:0]; bus.pwm_presc = pr[3:0];
        bus.pwm_en = 1'b1;
        cyc();
        chk("start_busy", {31'd0, bus.busy}, 32'd1);
        chk("start_cnt",  {16'd0, bus.pwm_cnt}, 32'd0);
        chk("start_out",  {31'd0, bus.pwm_out}, {31'd0, d != 0});
    endtask

    task automatic stop_wait();
        bit idle = 0;
        bus.pwm_en = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            cyc();
            if (!bus.busy) idle = 1;
        end
        chk("stop_idle", {31'd0, idle}, 32'd1);
    endtask

    initial begin
        int hi, irqs;
        bit [4:0] pat;
        bus.pwm_en = 1'b0; bus.pwm_presc = 4'd0;
        bus.period_cfg = 16'd0; bus.duty_cfg = 16'd0;
        cyc(); cyc();
        puc_rst = 1'b0;
        cyc();
        chk("reset_cnt", {16'd0, bus.pwm_cnt}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);

        // Reset mid-period
        start(4, 2, 0);
        wait_cnt(3, 10);
        puc_rst = 1'b1; bus.pwm_en = 1'b0;
        cyc();
        puc_rst = 1'b0;
        chk("rst_out",  {31'd0, bus.pwm_out}, 32'd0);
        chk("rst_cnt",  {16'd0, bus.pwm_cnt}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_irq",  {31'd0, bus.period_irq}, 32'd0);

        // Basic waveform 1,1,0,0,0 with irq on each wrap
        start(4, 2, 0);
        pat = 5'b00011;
        for (int i = 0; i < 15; i++) begin
            chk("wave_out", {31'd0, bus.pwm_out}, {31'd0, pat[i % 5]});
            chk("wave_irq", {31'd0, bus.period_irq}, {31'd0, (i % 5 == 0) && (i > 0)});
            cyc();
        end
        stop_wait();

        // Duty extremes
        start(4, 0, 0);
        hi = 0;
        for (int i = 0; i < 12; i++) begin cyc(); hi += int'(bus.pwm_out); end
        chk("duty0_hi", hi, 0);
        stop_wait();
        start(4, 5, 0);
        hi = 0;
        for (int i = 0; i < 12; i++) begin cyc(); hi += int'(bus.pwm_out); end
        chk("dutybig_hi", hi, 12);
        stop_wait();
        start(0, 1, 0);
        irqs = 0;
        for (int i = 0; i < 10; i++) begin cyc(); irqs += int'(bus.period_irq); end
        chk("per0_irqs", irqs, 10);
        stop_wait();

        // Shadow reload at cnt=2
        start(4, 2, 0);
        wait_cnt(2, 10);
        bus.period_cfg = 16'd9; bus.duty_cfg = 16'd7;
        cyc(); cyc();
        chk("reload_old", {16'd0, bus.pwm_cnt}, 32'd4);
        cyc();
        chk("reload_irq", {31'd0, bus.period_irq}, 32'd1);
        hi = int'(bus.pwm_out);
        for (int i = 0; i < 9; i++) begin cyc(); hi += int'(bus.pwm_out); end
        chk("reload_hi", hi, 7);
        cyc();
        chk("reload_wrap", {15'd0, bus.period_irq, bus.pwm_cnt}, 32'h10000);
        stop_wait();

        // Drain to idle
        start(4, 2, 0);
        wait_cnt(1, 10);
        bus.pwm_en = 1'b0;
        cyc(); cyc(); cyc();
        chk("drain_cnt4", {16'd0, bus.pwm_cnt}, 32'd4);
        cyc();
        chk("drain_irq",  {31'd0, bus.period_irq}, 32'd1);
        chk("drain_busy", {31'd0, bus.busy}, 32'd0);
        chk("drain_out",  {31'd0, bus.pwm_out}, 32'd0);

        // Drain cancelled by re-raising pwm_en
        start(4, 2, 0);
        wait_cnt(1, 10);
        bus.pwm_en = 1'b0;
        wait_cnt(3, 10);
        bus.pwm_en = 1'b1;
        for (int i = 0; i < 12; i++) cyc();
        chk("undrain_busy", {31'd0, bus.busy}, 32'd1);
        stop_wait();

        // Prescaler
        start(9, 3, 2);
        cyc(); cyc();
        chk("presc_hold", {16'd0, bus.pwm_cnt}, 32'd0);
        cyc();
        chk("presc_step", {16'd0, bus.pwm_cnt}, 32'd1);
        stop_wait();
        start(9, 3, 3);
        cyc(); cyc();
        bus.pwm_presc = 4'd1;
        cyc();
        chk("presc_lower", {16'd0, bus.pwm_cnt}, 32'd1);
        stop_wait();

        // Randomized traffic against the reference
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) bus.pwm_en = ~bus.pwm_en;
            if ($urandom_range(0, 19) == 0) begin
                bus.period_cfg = ($urandom_range(0, 31) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
                bus.duty_cfg   = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 49) == 0) bus.pwm_presc = 4'($urandom_range(0, 3));
            puc_rst = ($urandom_range(0, 499) == 0);
            cyc();
        end
        puc_rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
